// File: rtl/cpu64_l1_mem_arbiter.sv
// Two-port L1 memory arbiter: round-robin with line lock, in-order read ID FIFO
// routing memory responses back to the issuing port.
module cpu64_l1_mem_arbiter #(
    parameter int unsigned NUM_OUTSTANDING = 4
) (
    input  logic                                   clk_i,
    input  logic                                   rst_ni,
    // Port 0 (I-side)
    input  logic                                   p0_req_i,
    input  logic                                   p0_we_i,
    input  logic [7:0]                             p0_be_i,
    input  logic [63:0]                            p0_addr_i,
    input  logic [63:0]                            p0_wdata_i,
    input  logic                                   p0_lock_i,
    output logic                                   p0_gnt_o,
    output logic                                   p0_rvalid_o,
    output logic [63:0]                            p0_rdata_o,
    // Port 1 (D-side)
    input  logic                                   p1_req_i,
    input  logic                                   p1_we_i,
    input  logic [7:0]                             p1_be_i,
    input  logic [63:0]                            p1_addr_i,
    input  logic [63:0]                            p1_wdata_i,
    input  logic                                   p1_lock_i,
    output logic                                   p1_gnt_o,
    output logic                                   p1_rvalid_o,
    output logic [63:0]                            p1_rdata_o,
    // Memory side
    output logic                                   mem_req_o,
    output logic                                   mem_we_o,
    output logic [7:0]                             mem_be_o,
    output logic [63:0]                            mem_addr_o,
    output logic [63:0]                            mem_wdata_o,
    input  logic                                   mem_gnt_i,
    input  logic                                   mem_rvalid_i,
    input  logic [63:0]                            mem_rdata_i,
    // Status
    output logic [$clog2(NUM_OUTSTANDING+1)-1:0]   outstanding_o,
    output logic                                   err_o
);

    localparam int unsigned CntW = $clog2(NUM_OUTSTANDING + 1);
    localparam int unsigned PtrW = $clog2(NUM_OUTSTANDING);

    logic                       prio_q;
    logic                       locked_q;
    logic                       owner_q;
    logic                       err_q;
    logic [CntW-1:0]            count_q;
    logic [PtrW-1:0]            wptr_q;
    logic [PtrW-1:0]            rptr_q;
    logic [NUM_OUTSTANDING-1:0] fifo_q;

    logic            full;
    logic            elig0;
    logic            elig1;
    logic            sel_valid;
    logic            sel_port;
    logic            sel_lock;
    logic            hs;
    logic            push;
    logic            pop;
    logic            head;
    logic            owner_req;
    logic            owner_lock;
    logic [CntW-1:0] count_d;

    // Eligibility, selection and memory-side mux
    always_comb begin
        // Full check deliberately ignores a same-cycle pop
        full  = (count_q == CntW'(NUM_OUTSTANDING));
        elig0 = p0_req_i && !(!p0_we_i && full) && (!locked_q || !owner_q);
        elig1 = p1_req_i && !(!p1_we_i && full) && (!locked_q || owner_q);

        sel_valid = elig0 || elig1;
        sel_port  = (elig0 && elig1) ? prio_q : elig1;

        mem_req_o   = sel_valid;
        mem_we_o    = sel_port ? p1_we_i    : p0_we_i;
        mem_be_o    = sel_port ? p1_be_i    : p0_be_i;
        mem_addr_o  = sel_port ? p1_addr_i  : p0_addr_i;
        mem_wdata_o = sel_port ? p1_wdata_i : p0_wdata_i;
        sel_lock    = sel_port ? p1_lock_i  : p0_lock_i;

        hs       = mem_req_o && mem_gnt_i;
        p0_gnt_o = hs && !sel_port;
        p1_gnt_o = hs && sel_port;

        owner_req  = owner_q ? p1_req_i  : p0_req_i;
        owner_lock = owner_q ? p1_lock_i : p0_lock_i;
    end

    // Response routing and FIFO count update
    always_comb begin
        push = hs && !mem_we_o;
        pop  = mem_rvalid_i && (count_q != '0);
        head = fifo_q[rptr_q];

        p0_rvalid_o = pop && !head;
        p1_rvalid_o = pop && head;
        p0_rdata_o  = mem_rdata_i;
        p1_rdata_o  = mem_rdata_i;

        count_d = count_q;
        if (push && !pop) begin
            count_d = count_q + CntW'(1);
        end else if (pop && !push) begin
            count_d = count_q - CntW'(1);
        end
    end

    // Arbitration state: priority, lock ownership and sticky error
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            prio_q   <= 1'b0;
            locked_q <= 1'b0;
            owner_q  <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            if (hs) begin
                if (sel_lock) begin
                    locked_q <= 1'b1;
                    owner_q  <= sel_port;
                end else begin
                    locked_q <= 1'b0;
                    prio_q   <= ~sel_port;
                end
            end else if (locked_q && !owner_req && !owner_lock) begin
                // Owner walked away without finishing the line: release, keep priority
                locked_q <= 1'b0;
            end
            if (mem_rvalid_i && (count_q == '0)) begin
                err_q <= 1'b1;
            end
        end
    end

    // In-order read ID FIFO
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            fifo_q  <= '0;
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) begin
                fifo_q[wptr_q] <= sel_port;
                wptr_q         <= wptr_q + PtrW'(1);
            end
            if (pop) begin
                rptr_q <= rptr_q + PtrW'(1);
            end
            count_q <= count_d;
        end
    end

    assign outstanding_o = count_q;
    assign err_o         = err_q;

endmodule

// File: tb/tb_cpu64_l1_mem_arbiter.sv
// Directed self-checking bench for cpu64_l1_mem_arbiter.
module tb_cpu64_l1_mem_arbiter;

    logic        clk_i = 1'b0;
    logic        rst_ni;
    logic        p0_req_i, p0_we_i, p0_lock_i;
    logic [7:0]  p0_be_i;
    logic [63:0] p0_addr_i, p0_wdata_i;
    logic        p1_req_i, p1_we_i, p1_lock_i;
    logic [7:0]  p1_be_i;
    logic [63:0] p1_addr_i, p1_wdata_i;
    logic        p0_gnt_o, p0_rvalid_o, p1_gnt_o, p1_rvalid_o;
    logic [63:0] p0_rdata_o, p1_rdata_o;
    logic        mem_req_o, mem_we_o;
    logic [7:0]  mem_be_o;
    logic [63:0] mem_addr_o, mem_wdata_o;
    logic        mem_gnt_i;
    logic        mem_rvalid_i;
    logic [63:0] mem_rdata_i;
    logic [2:0]  outstanding_o;
    logic        err_o;

    int checks   = 0;
    int failures = 0;

    // Memory model: fixed 2-cycle read latency, or manual responses
    logic        auto_en;
    logic        man_rvalid;
    logic [63:0] man_rdata;
    logic [1:0]  pv = 2'b00;
    logic [63:0] pd0 = '0;
    logic [63:0] pd1 = '0;

    always #5 clk_i = ~clk_i;

    always @(posedge clk_i) begin
        pv[0] <= auto_en & mem_req_o & mem_gnt_i & ~mem_we_o;
        pd0   <= (mem_addr_o == 64'h40) ? 64'h1122_3344_5566_7788
                                        : (64'hA000_0000_0000_0000 | mem_addr_o);
        pv[1] <= pv[0];
        pd1   <= pd0;
    end

    assign mem_rvalid_i = auto_en ? pv[1] : man_rvalid;
    assign mem_rdata_i  = auto_en ? pd1   : man_rdata;

    cpu64_l1_mem_arbiter #(.NUM_OUTSTANDING(4)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .p0_req_i(p0_req_i), .p0_we_i(p0_we_i), .p0_be_i(p0_be_i), .p0_addr_i(p0_addr_i),
        .p0_wdata_i(p0_wdata_i), .p0_lock_i(p0_lock_i), .p0_gnt_o(p0_gnt_o),
        .p0_rvalid_o(p0_rvalid_o), .p0_rdata_o(p0_rdata_o),
        .p1_req_i(p1_req_i), .p1_we_i(p1_we_i), .p1_be_i(p1_be_i), .p1_addr_i(p1_addr_i),
        .p1_wdata_i(p1_wdata_i), .p1_lock_i(p1_lock_i), .p1_gnt_o(p1_gnt_o),
        .p1_rvalid_o(p1_rvalid_o), .p1_rdata_o(p1_rdata_o),
        .mem_req_o(mem_req_o), .mem_we_o(mem_we_o), .mem_be_o(mem_be_o),
        .mem_addr_o(mem_addr_o), .mem_wdata_o(mem_wdata_o), .mem_gnt_i(mem_gnt_i),
        .mem_rvalid_i(mem_rvalid_i), .mem_rdata_i(mem_rdata_i),
        .outstanding_o(outstanding_o), .err_o(err_o)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        p0_req_i = 0; p0_we_i = 0; p0_be_i = '0; p0_addr_i = '0; p0_wdata_i = '0; p0_lock_i = 0;
        p1_req_i = 0; p1_we_i = 0; p1_be_i = '0; p1_addr_i = '0; p1_wdata_i = '0; p1_lock_i = 0;
        mem_gnt_i = 0; auto_en = 1; man_rvalid = 0; man_rdata = '0;
        #3;
        check_eq("rst_mem_req", mem_req_o, 0);
        check_eq("rst_gnt", {p0_gnt_o, p1_gnt_o}, 0);
        check_eq("rst_rvalid", {p0_rvalid_o, p1_rvalid_o}, 0);
        check_eq("rst_mem_addr", mem_addr_o, 0);
        check_eq("rst_mem_we_be", {mem_we_o, mem_be_o}, 0);
        check_eq("rst_outstanding", outstanding_o, 0);
        check_eq("rst_err", err_o, 0);
        repeat (2) tick();
        rst_ni = 1'b1;
        tick();

        // Single read from port 1
        p1_req_i = 1; p1_we_i = 0; p1_addr_i = 64'h40; mem_gnt_i = 1;
        #1;
        check_eq("rd_p1_gnt", p1_gnt_o, 1);
        check_eq("rd_p0_gnt", p0_gnt_o, 0);
        check_eq("rd_mem_addr", mem_addr_o, 64'h40);
        tick();
        p1_req_i = 0;
        #1;
        check_eq("rd_outst_1", outstanding_o, 1);
        check_eq("rd_c1_rvalid", p1_rvalid_o, 0);
        tick();
        #1;
        check_eq("rd_c2_p1_rvalid", p1_rvalid_o, 1);
        check_eq("rd_c2_p1_rdata", p1_rdata_o, 64'h1122_3344_5566_7788);
        check_eq("rd_c2_p0_rvalid", p0_rvalid_o, 0);
        tick();
        check_eq("rd_outst_0", outstanding_o, 0);

        // Both ports reading continuously: alternate grants, in-order routing
        p0_addr_i = 64'h200; p1_addr_i = 64'h300;
        for (int c = 0; c < 6; c++) begin
            p0_req_i = (c < 4);
            p1_req_i = (c < 4);
            #1;
            if (c < 4) begin
                check_eq("rr_p0_gnt", p0_gnt_o, (c % 2 == 0));
                check_eq("rr_p1_gnt", p1_gnt_o, (c % 2 == 1));
            end
            if (c >= 2) begin
                check_eq("rr_p0_rvalid", p0_rvalid_o, (c % 2 == 0));
                check_eq("rr_p1_rvalid", p1_rvalid_o, (c % 2 == 1));
                check_eq("rr_rdata", p0_rdata_o,
                         (c % 2 == 0) ? 64'hA000_0000_0000_0200 : 64'hA000_0000_0000_0300);
            end
            tick();
        end
        check_eq("rr_outst_0", outstanding_o, 0);

        // Locked 8-beat write burst from port 0 while port 1 keeps requesting
        for (int i = 0; i < 9; i++) begin
            p0_req_i = 1; p0_we_i = 1; p0_be_i = 8'hFF;
            p0_addr_i = 64'h100 + 64'(8 * i); p0_wdata_i = 64'hCAFE_0000 + 64'(i);
            p0_lock_i = (i < 7);
            p1_req_i = 1; p1_we_i = 0; p1_addr_i = 64'h300;
            #1;
            if (i < 8) begin
                check_eq("lk_p0_gnt", p0_gnt_o, 1);
                check_eq("lk_p1_gnt", p1_gnt_o, 0);
                check_eq("lk_addr", mem_addr_o, 64'h100 + 64'(8 * i));
            end else begin
                check_eq("lk_after_p1_gnt", p1_gnt_o, 1);
                check_eq("lk_after_p0_gnt", p0_gnt_o, 0);
            end
            if (i == 3) begin
                check_eq("lk_we_be", {mem_we_o, mem_be_o}, 9'h1FF);
                check_eq("lk_wdata", mem_wdata_o, 64'hCAFE_0003);
            end
            tick();
        end
        p0_req_i = 0; p0_we_i = 0; p0_lock_i = 0; p1_req_i = 0;
        repeat (3) tick();
        check_eq("lk_outst_0", outstanding_o, 0);

        // FIFO full with responses withheld
        auto_en = 0;
        p0_we_i = 0; p0_addr_i = 64'h500;
        for (int c = 0; c < 4; c++) begin
            p0_req_i = 1;
            #1;
            check_eq("full_fill_gnt", p0_gnt_o, 1);
            tick();
        end
        check_eq("full_outst_4", outstanding_o, 4);
        p1_req_i = 1; p1_we_i = 1; p1_addr_i = 64'h600;
        #1;
        check_eq("full_p0_nogrant", p0_gnt_o, 0);
        check_eq("full_p1_wr_gnt", p1_gnt_o, 1);
        check_eq("full_wr_addr", mem_addr_o, 64'h600);
        tick();
        p1_req_i = 0; p1_we_i = 0;
        man_rvalid = 1; man_rdata = 64'hBEEF;
        #1;
        check_eq("full_pop_rvalid", p0_rvalid_o, 1);
        check_eq("full_pop_rdata", p0_rdata_o, 64'hBEEF);
        check_eq("full_pop_p1_rvalid", p1_rvalid_o, 0);
        check_eq("full_same_cycle_gnt", p0_gnt_o, 0);
        tick();
        man_rvalid = 0;
        #1;
        check_eq("full_outst_3", outstanding_o, 3);
        check_eq("full_next_gnt", p0_gnt_o, 1);
        tick();
        p0_req_i = 0;
        check_eq("full_outst_4b", outstanding_o, 4);
        for (int k = 0; k < 4; k++) begin
            man_rvalid = 1;
            tick();
        end
        man_rvalid = 0;
        check_eq("drain_outst_0", outstanding_o, 0);
        check_eq("drain_err_0", err_o, 0);

        // Spurious response sets sticky error
        man_rvalid = 1;
        #1;
        check_eq("err_no_rvalid", {p0_rvalid_o, p1_rvalid_o}, 0);
        check_eq("err_not_yet", err_o, 0);
        tick();
        man_rvalid = 0;
        #1;
        check_eq("err_set", err_o, 1);

        // Asynchronous reset with reads in flight
        p1_req_i = 1; p1_we_i = 0; p1_addr_i = 64'h700;
        repeat (3) tick();
        p1_req_i = 0;
        #1;
        check_eq("pre_rst_outst_3", outstanding_o, 3);
        #2;
        rst_ni = 0;
        #1;
        check_eq("async_rst_outst", outstanding_o, 0);
        check_eq("async_rst_err", err_o, 0);
        check_eq("async_rst_req", mem_req_o, 0);
        tick();
        #2;
        rst_ni = 1;
        tick();
        man_rvalid = 1;
        #1;
        check_eq("post_rst_no_rvalid", {p0_rvalid_o, p1_rvalid_o}, 0);
        tick();
        man_rvalid = 0;
        check_eq("post_rst_err", err_o, 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
